// File: rtl/bpsk_demodulator.sv
// BPSK receiver: square-reference correlator, sync-word hunt with phase
// ambiguity resolution, and fixed-length payload byte assembly.
module bpsk_demodulator #(
    parameter int                    DATA_WIDTH      = 12,
    parameter int                    SAMPLES_PER_BIT = 32,
    parameter int                    SYNC_WIDTH      = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD       = 16'hD391,
    parameter int                    PAYLOAD_BYTES   = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  sample_valid,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  locked,
    output logic                  inverted,
    output logic [7:0]            byte_data,
    output logic                  byte_valid,
    output logic                  frame_done
);

    localparam int ACC_W = DATA_WIDTH + $clog2(SAMPLES_PER_BIT) + 1;
    localparam int K_W   = $clog2(SAMPLES_PER_BIT);
    localparam int BC_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    localparam logic [K_W-1:0]  K_LAST    = K_W'(SAMPLES_PER_BIT - 1);
    localparam logic [K_W-1:0]  K_HALF    = K_W'(SAMPLES_PER_BIT / 2);
    localparam logic [BC_W-1:0] BYTE_LAST = BC_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Offset binary minus midpoint is just an MSB flip, then sign-extend.
    function automatic logic signed [ACC_W-1:0] center_sample(input logic [DATA_WIDTH-1:0] raw);
        logic [DATA_WIDTH-1:0] twos;
        twos = {~raw[DATA_WIDTH-1], raw[DATA_WIDTH-2:0]};
        return $signed({{(ACC_W-DATA_WIDTH){twos[DATA_WIDTH-1]}}, twos});
    endfunction

    state_t                  state_r;
    logic [K_W-1:0]          k_r;
    logic signed [ACC_W-1:0] acc_r;
    logic                    raw_bit_r;
    logic [SYNC_WIDTH-2:0]   sync_r;
    logic [2:0]              bit_cnt_r;
    logic [BC_W-1:0]         byte_cnt_r;
    logic [6:0]              byte_sr_r;
    logic                    bit_out_r;
    logic                    bit_valid_r;
    logic                    locked_r;
    logic                    inverted_r;
    logic [7:0]              byte_data_r;
    logic                    byte_valid_r;
    logic                    frame_done_r;

    logic                    accept_s;
    logic signed [ACC_W-1:0] s_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [SYNC_WIDTH-1:0]   sync_next_s;
    logic [7:0]              byte_next_s;

    // Correlator next sum and the shift-register views including the newest bit
    always_comb begin
        accept_s    = enable && sample_valid && (state_r != ST_IDLE);
        s_ext_s     = center_sample(sample);
        if (k_r < K_HALF) begin
            sum_s = acc_r + s_ext_s;
        end else begin
            sum_s = acc_r - s_ext_s;
        end
        sync_next_s = {sync_r, raw_bit_r};
        byte_next_s = {byte_sr_r, bit_out_r};
    end

    // Receiver state machine: correlation, sync hunt, byte assembly, pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            k_r          <= '0;
            acc_r        <= '0;
            raw_bit_r    <= 1'b0;
            sync_r       <= '0;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= '0;
            byte_sr_r    <= 7'd0;
            bit_out_r    <= 1'b0;
            bit_valid_r  <= 1'b0;
            locked_r     <= 1'b0;
            inverted_r   <= 1'b0;
            byte_data_r  <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            bit_valid_r  <= 1'b0;
            byte_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
            if (!enable) begin
                state_r     <= ST_IDLE;
                k_r         <= '0;
                acc_r       <= '0;
                raw_bit_r   <= 1'b0;
                sync_r      <= '0;
                bit_cnt_r   <= 3'd0;
                byte_cnt_r  <= '0;
                byte_sr_r   <= 7'd0;
                bit_out_r   <= 1'b0;
                locked_r    <= 1'b0;
                inverted_r  <= 1'b0;
                byte_data_r <= 8'd0;
            end else begin
                if (accept_s) begin
                    if (k_r == K_LAST) begin
                        // A zero sum decodes as 1, hence the sign-bit test.
                        k_r         <= '0;
                        acc_r       <= '0;
                        raw_bit_r   <= ~sum_s[ACC_W-1];
                        bit_out_r   <= ~sum_s[ACC_W-1] ^ inverted_r;
                        bit_valid_r <= 1'b1;
                    end else begin
                        k_r   <= k_r + 1'b1;
                        acc_r <= sum_s;
                    end
                end
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_HUNT;
                    end
                    ST_HUNT: begin
                        if (bit_valid_r) begin
                            sync_r <= sync_next_s[SYNC_WIDTH-2:0];
                            if (sync_next_s == SYNC_WORD) begin
                                state_r    <= ST_PAYLOAD;
                                locked_r   <= 1'b1;
                                inverted_r <= 1'b0;
                            end else if (sync_next_s == ~SYNC_WORD) begin
                                state_r    <= ST_PAYLOAD;
                                locked_r   <= 1'b1;
                                inverted_r <= 1'b1;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (frame_done_r) begin
                            // Fresh hunt: stale payload history must not form a sync.
                            state_r    <= ST_HUNT;
                            locked_r   <= 1'b0;
                            inverted_r <= 1'b0;
                            sync_r     <= '0;
                            bit_cnt_r  <= 3'd0;
                            byte_cnt_r <= '0;
                            byte_sr_r  <= 7'd0;
                        end else if (bit_valid_r) begin
                            byte_sr_r <= byte_next_s[6:0];
                            if (bit_cnt_r == 3'd7) begin
                                bit_cnt_r    <= 3'd0;
                                byte_data_r  <= byte_next_s;
                                byte_valid_r <= 1'b1;
                                if (byte_cnt_r == BYTE_LAST) begin
                                    frame_done_r <= 1'b1;
                                end else begin
                                    byte_cnt_r <= byte_cnt_r + 1'b1;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bit_out    = bit_out_r;
    assign bit_valid  = bit_valid_r;
    assign locked     = locked_r;
    assign inverted   = inverted_r;
    assign byte_data  = byte_data_r;
    assign byte_valid = byte_valid_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Scoreboard bench for bpsk_demodulator: a symbol-level model predicts
// every bit and byte; a negedge monitor pops and compares.
module tb_bpsk_demodulator;

    localparam int          DW     = 12;
    localparam int          SPB    = 32;
    localparam int          NBYTES = 22;
    localparam int          MID    = 2048;
    localparam logic [15:0] SYNC   = 16'hD391;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] sample = 12'd2048;
    logic          sample_valid = 1'b0;
    logic          bit_out, bit_valid, locked, inverted, byte_valid, frame_done;
    logic [7:0]    byte_data;

    bpsk_demodulator #(
        .DATA_WIDTH(DW), .SAMPLES_PER_BIT(SPB), .SYNC_WIDTH(16),
        .SYNC_WORD(SYNC), .PAYLOAD_BYTES(NBYTES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample(sample),
        .sample_valid(sample_valid), .bit_out(bit_out), .bit_valid(bit_valid),
        .locked(locked), .inverted(inverted), .byte_data(byte_data),
        .byte_valid(byte_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    typedef struct { logic b; logic lk; int t; } bit_exp_t;
    typedef struct { logic [7:0] d; logic last; logic inv; int t; } byte_exp_t;

    bit_exp_t   exp_bits[$];
    byte_exp_t  exp_bytes[$];
    logic [7:0] rx_bytes[$];
    int         errors = 0;
    int         checks = 0;
    int         frames_seen = 0;

    // Reference model state: frame parser over the decided bit stream
    bit          m_hunt = 1'b1;
    logic [15:0] m_sreg = 16'h0000;
    bit          m_inv = 1'b0;
    logic [7:0]  m_cur = 8'h00;
    int          m_nbits = 0;
    int          m_nbytes = 0;
    int          m_frames = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected at tick %0d", name, tick);
    endtask

    task automatic model_reset();
        m_hunt = 1'b1; m_sreg = 16'h0000; m_inv = 1'b0;
        m_cur = 8'h00; m_nbits = 0; m_nbytes = 0;
    endtask

    task automatic model_bit(input bit raw, input int t);
        bit_exp_t  e;
        byte_exp_t y;
        e.lk = !m_hunt;
        e.t  = t + 1;
        if (m_hunt) begin
            e.b = raw;
            exp_bits.push_back(e);
            m_sreg = {m_sreg[14:0], raw};
            if (m_sreg == SYNC || m_sreg == ~SYNC) begin
                m_hunt = 1'b0;
                m_inv = (m_sreg != SYNC);
                m_nbits = 0;
                m_nbytes = 0;
            end
        end else begin
            e.b = raw ^ m_inv;
            exp_bits.push_back(e);
            m_cur = {m_cur[6:0], e.b};
            m_nbits++;
            if (m_nbits == 8) begin
                y.d = m_cur; y.last = (m_nbytes == NBYTES - 1); y.inv = m_inv; y.t = t + 2;
                exp_bytes.push_back(y);
                m_nbytes++;
                m_nbits = 0;
                if (y.last) begin
                    m_hunt = 1'b1;
                    m_sreg = 16'h0000;
                    m_inv = 1'b0;
                    m_frames++;
                end
            end
        end
    endtask

    // Monitor: compare every DUT pulse against the scoreboard queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (bit_valid) begin
                if (exp_bits.size() == 0) begin
                    fail_event("spurious_bit_valid");
                end else begin
                    bit_exp_t e;
                    e = exp_bits.pop_front();
                    check("bit_out", bit_out, e.b);
                    check("bit_time", tick, e.t);
                    check("locked_at_bit", locked, e.lk);
                end
            end
            if (byte_valid) begin
                rx_bytes.push_back(byte_data);
                if (frame_done) frames_seen++;
                if (exp_bytes.size() == 0) begin
                    fail_event("spurious_byte_valid");
                end else begin
                    byte_exp_t y;
                    y = exp_bytes.pop_front();
                    check("byte_data", byte_data, y.d);
                    check("frame_done", frame_done, y.last);
                    check("inverted", inverted, y.inv);
                    check("byte_time", tick, y.t);
                    check("locked_at_byte", locked, 1);
                end
            end else if (frame_done) begin
                fail_event("frame_done_without_byte");
            end
        end
    end

    task automatic drive_sample(input logic [DW-1:0] v, input int gap);
        @(negedge clk);
        sample = v;
        sample_valid = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            sample_valid = 1'b0;
            sample = 12'($urandom);
        end
    endtask

    // mode 0: full amplitude, 1: random amplitude with noise, 2: midpoint, 3: uniform random
    task automatic send_symbol(input bit b, input bit phase, input int gap, input int mode);
        int vals[SPB];
        int sum = 0;
        int sgn = (b ^ phase) ? 1 : -1;
        int amp = $urandom_range(1364, 200);
        for (int k = 0; k < SPB; k++) begin
            int s;
            int half = (k < SPB / 2) ? sgn : -sgn;
            case (mode)
                0: s = half * 2047;
                1: s = half * amp + int'($urandom_range(amp, 0)) - amp / 2;
                2: s = 0;
                default: s = int'($urandom_range(4095, 0)) - MID;
            endcase
            vals[k] = MID + s;
            sum += (k < SPB / 2) ? s : -s;
        end
        for (int k = 0; k < SPB - 1; k++) drive_sample(12'(vals[k]), gap);
        @(negedge clk);
        sample = 12'(vals[SPB-1]);
        sample_valid = 1'b1;
        model_bit(sum >= 0, tick);
        repeat (gap) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input bit phase, input int gap, input int mode);
        for (int i = n - 1; i >= 0; i--) send_symbol(w[i], phase, gap, mode);
    endtask

    task automatic send_frame(input logic [15:0] sw, input int nb, input bit phase, input int gap, input int mode);
        send_bits(sw, 16, phase, gap, mode);
        for (int by = 0; by < nb; by++) send_bits({8'h00, 8'(by)}, 8, phase, gap, mode);
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(negedge clk);
        sample_valid = 1'b0;
        while ((exp_bits.size() != 0 || exp_bytes.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check(name, exp_bits.size() + exp_bytes.size(), 0);
        exp_bits.delete();
        exp_bytes.delete();
    endtask

    task automatic check_rx(input string name, input int n);
        check(name, rx_bytes.size(), n);
        for (int i = 0; i < rx_bytes.size() && i < n; i++) check(name, rx_bytes[i], i);
        rx_bytes.delete();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_bit_valid"}, bit_valid, 0);
        check({name, "_bit_out"}, bit_out, 0);
        check({name, "_locked"}, locked, 0);
        check({name, "_inverted"}, inverted, 0);
        check({name, "_byte_data"}, byte_data, 0);
        check({name, "_byte_valid"}, byte_valid, 0);
        check({name, "_frame_done"}, frame_done, 0);
    endtask

    task automatic start_rx();
        model_reset();
        @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Sync, five payload bytes, three more bits and a partial symbol
    task automatic partial_frame();
        send_frame(SYNC, 5, 1'b0, 0, 0);
        send_bits(16'h0005, 3, 1'b0, 0, 0);
        for (int k = 0; k < 10; k++) drive_sample(12'd4095, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        start_rx();

        send_frame(SYNC, NBYTES, 1'b0, 0, 0);
        drain("clean_drain");
        check("clean_locked_after", locked, 0);
        check_rx("clean_bytes", NBYTES);

        send_frame(SYNC, NBYTES, 1'b1, 0, 0);
        drain("inverted_drain");
        check_rx("inverted_bytes", NBYTES);

        send_frame(SYNC, NBYTES, 1'b0, 3, 1);
        drain("gap_drain");
        check_rx("gap_bytes", NBYTES);

        send_frame(16'hD390, 4, 1'b0, 0, 1);
        drain("nearmiss_drain");
        check("nearmiss_locked", locked, 0);
        check_rx("nearmiss_bytes", 0);
        send_frame(SYNC, NBYTES, 1'b0, 0, 0);
        drain("nearmiss_relock_drain");
        check_rx("nearmiss_relock_bytes", NBYTES);

        for (int i = 0; i < 40; i++) send_symbol(1'b0, 1'b0, 0, 2);
        drain("zero_drain");
        check("zero_locked", locked, 0);
        check_rx("zero_bytes", 0);

        for (int i = 0; i < 64; i++) send_symbol(1'b0, 1'b0, $urandom_range(1, 0), 3);
        drain("random_drain");
        rx_bytes.delete();
        @(negedge clk);
        enable = 1'b0;
        start_rx();

        partial_frame();
        @(negedge clk);
        enable = 1'b0;
        sample_valid = 1'b1;
        sample = 12'd4095;
        repeat (3) @(negedge clk);
        sample_valid = 1'b0;
        check_quiet("en_abort");
        drain("en_abort_drain");
        check_rx("en_abort_bytes", 5);
        start_rx();
        send_frame(SYNC, NBYTES, 1'b0, 0, 0);
        drain("en_reframe_drain");
        check_rx("en_reframe_bytes", NBYTES);

        partial_frame();
        @(negedge clk);
        rst_n = 1'b0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("rst_abort");
        check_rx("rst_abort_bytes", 5);
        exp_bits.delete();
        exp_bytes.delete();
        rst_n = 1'b1;
        start_rx();
        check_quiet("rst_release");
        send_frame(SYNC, NBYTES, 1'b0, 0, 0);
        drain("rst_reframe_drain");
        check_rx("rst_reframe_bytes", NBYTES);

        check("frame_count", frames_seen, m_frames);
        check("frame_min", frames_seen >= 6, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bpsk_demodulator.md
Name: bpsk_demodulator

Overview:
Receive-side counterpart of the BPSK transmit chain. Takes offset-binary ADC samples of the BPSK carrier, correlates each symbol period against a one-cycle square reference to recover bits, hunts for a sync word, then emits a fixed-length payload as bytes. The byte stream feeds a UART byte writer back to the host. Symbol timing is fixed: symbol boundaries align to the first accepted sample after `enable` rises, which suits the loopback/shared-clock test path.

Parameters:
DATA_WIDTH, 12, ADC sample width, offset binary with midpoint 2^(DATA_WIDTH-1).
SAMPLES_PER_BIT, 32, samples per symbol. Must be even and at least 4. One carrier cycle per symbol.
SYNC_WIDTH, 16, sync word length in bits.
SYNC_WORD, 16'hD391, sync pattern, transmitted MSB first.
PAYLOAD_BYTES, 22, bytes per frame after sync. Must be at least 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  receiver run. Low forces IDLE.
sample  in  DATA_WIDTH  ADC sample
sample_valid  in  1  sample strobe, one sample per high cycle
bit_out  out  1  recovered bit, polarity-corrected once locked
bit_valid  out  1  one-cycle pulse per recovered bit
locked  out  1  high while in PAYLOAD
inverted  out  1  sync was matched inverted (180-degree phase ambiguity)
byte_data  out  8  payload byte, MSB first
byte_valid  out  1  one-cycle pulse per payload byte
frame_done  out  1  one-cycle pulse after the last payload byte

Behaviour:
- Reset: all outputs 0. State IDLE. Accumulator, sample counter, sync shift register, bit counter and byte counter are all cleared.
- Correlator:
  - Signed sample s = sample - 2^(DATA_WIDTH-1), extended to ACC_W = DATA_WIDTH + clog2(SAMPLES_PER_BIT) + 1 bits.
  - Sample index k = 0..SAMPLES_PER_BIT-1. Add s when k < SAMPLES_PER_BIT/2, else subtract s.
  - Counter and accumulator advance only on cycles with `sample_valid`. Gaps pause the correlator with no loss.
- Bit decision:
  - On the sample with k = SAMPLES_PER_BIT-1, take the final sum (including that sample).
  - raw_bit = 1 if final sum >= 0, else 0. A sum of exactly 0 decodes as 1.
  - The accumulator restarts at 0 with the next sample. There is no dead cycle between symbols.
- Bit latency: `bit_valid` pulses in the cycle after the last sample of the symbol is accepted, with `bit_out` = raw_bit XOR `inverted`.
  - In HUNT, `inverted` is 0, so raw bits are shown.
  - `bit_valid` pulses in HUNT and PAYLOAD. It never pulses in IDLE.
- FSM:
  - IDLE: all counters and the sync register are held at 0. Go to HUNT when `enable` = 1.
  - HUNT: shift raw bits into the SYNC_WIDTH-bit register (new bit at the LSB).
    - Register (including the current bit) == SYNC_WORD: go to PAYLOAD, `inverted` = 0.
    - Register == ~SYNC_WORD: go to PAYLOAD, `inverted` = 1.
    - Matching is evaluated on the same cycle as the `bit_valid` for the completing bit. `locked` rises the next cycle.
  - PAYLOAD:
    - Corrected bits shift MSB-first into a byte register.
    - On every 8th bit, `byte_data` updates and `byte_valid` pulses one cycle after that bit's `bit_valid`. `byte_data` holds until the next byte.
    - After byte PAYLOAD_BYTES, `frame_done` pulses in the same cycle as the last `byte_valid`.
    - Next cycle: go to HUNT, with `locked`, `inverted`, the sync register and the counters all cleared.
- Sync register is cleared on every entry to HUNT, so payload bits cannot form a false sync with stale history. A new sync needs SYNC_WIDTH fresh bits.
- `enable` falling in any state: go to IDLE the next cycle. The partial symbol, partial byte and frame are discarded, with no `byte_valid` or `frame_done`. `locked` and `inverted` clear.
- `sample_valid` while `enable` = 0: ignored.
- `rst_n` asserted mid-frame: immediate return to the reset state. No pulse is completed.
- Back-to-back frames: HUNT resumes on the symbol after the last payload bit. The symbol phase is unchanged.

Test Plan:
- Clean frame: enable, feed sync 16'hD391 then 22 bytes 0x00..0x15 at full amplitude (s = ±2047 per the carrier phase). -> `locked` rises after bit 16; 22 `byte_valid` pulses with data 0x00..0x15; `frame_done` with byte 0x15; `locked` = 0 after.
- Inverted phase: same frame with carrier phase flipped. -> match on ~SYNC_WORD, `inverted` = 1, decoded bytes still 0x00..0x15.
- Sample gaps: insert 3 idle cycles between every sample of the clean frame. -> identical byte sequence; each `bit_valid` comes 1 cycle after the 32nd accepted sample.
- Near-miss sync: send 16'hD390 then payload. -> `locked` stays 0, no `byte_valid`; a later correct sync locks normally.
- Zero input: constant sample 2048. -> every sum is 0, `bit_out` = 1 on each `bit_valid`; 16'hFFFF never matches, so no lock.
- Abort: drop `enable` after byte 5, and in a separate run pulse `rst_n` low after byte 5. -> no further bytes, no `frame_done`, all outputs 0. Re-enable plus a clean frame decodes all 22 bytes.
